// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-host RAM port arbiter.
//   host_e     : host index (instruction port = 0, data port = 1)
//   NumHosts   : number of arbitrated hosts
//   other_host : the opposite host, used for round-robin pointer flips
package ram_arb_pkg;

  localparam int NumHosts = 2;

  typedef enum logic {
    HostInstr = 1'b0,
    HostData  = 1'b1
  } host_e;

  function automatic host_e other_host(host_e h);
    return (h == HostData) ? HostInstr : HostData;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the two hosts, the arbiter and the single-port RAM.
//   host_* : per-host request attributes, grant and routed response
//   mem_*  : single-port RAM request and its 1-cycle-later response
// Modports: slave = arbiter view, master = hosts/RAM (environment) view.
interface ram_port_arbiter_if import ram_arb_pkg::*; #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  localparam int BeWidth = DataWidth / 8;

  logic [NumHosts-1:0]                host_req_i;
  logic [NumHosts-1:0][AddrWidth-1:0] host_addr_i;
  logic [NumHosts-1:0]                host_we_i;
  logic [NumHosts-1:0][BeWidth-1:0]   host_be_i;
  logic [NumHosts-1:0][DataWidth-1:0] host_wdata_i;
  logic [NumHosts-1:0]                host_gnt_o;
  logic [NumHosts-1:0]                host_rvalid_o;
  logic [NumHosts-1:0][DataWidth-1:0] host_rdata_o;

  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [BeWidth-1:0]   mem_be_o;
  logic [AddrWidth-1:0] mem_addr_o;
  logic [DataWidth-1:0] mem_wdata_o;
  logic                 mem_rvalid_i;
  logic [DataWidth-1:0] mem_rdata_i;

  modport slave (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
           mem_rvalid_i, mem_rdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
           mem_rvalid_i, mem_rdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with a same-cycle (combinational) grant.
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_i        : per-host request
//   gnt_o        : one-hot (or zero) grant
// The priority pointer names the host that wins the next contention; it
// flips only when both hosts request, so lone requests never disturb it.
module rr_arbiter2 import ram_arb_pkg::*; (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumHosts-1:0] req_i,
  output logic [NumHosts-1:0] gnt_o
);

  host_e prio_q, prio_d;

  always_comb begin
    gnt_o  = '0;
    prio_d = prio_q;
    if (!rst_i) begin
      if (&req_i) begin
        gnt_o[prio_q] = 1'b1;
        prio_d        = other_host(prio_q);
      end else begin
        gnt_o = req_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) prio_q <= HostData;
    else       prio_q <= prio_d;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between the core instruction and data ports.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   bus            : host requests/grants/responses and RAM request/response
//   conflict_cnt_o : saturating count of cycles with both hosts requesting
//   spurious_o     : sticky, set by a RAM response with no outstanding owner
// The RAM answers exactly one cycle after each request, so a single
// registered owner (index + valid) is enough to steer responses back.
module ram_port_arbiter import ram_arb_pkg::*; #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int CntWidth  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  ram_port_arbiter_if.slave   bus,
  output logic [CntWidth-1:0] conflict_cnt_o,
  output logic                spurious_o
);

  localparam int BeWidth = DataWidth / 8;

  logic [NumHosts-1:0] gnt;
  host_e               gnt_idx;

  logic                owner_vld_q, owner_vld_d;
  host_e               owner_idx_q, owner_idx_d;
  logic                rst_dly_q, rst_dly_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                spurious_q, spurious_d;

  rr_arbiter2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (bus.host_req_i),
    .gnt_o (gnt)
  );

  assign gnt_idx = gnt[HostData] ? HostData : HostInstr;

  // Request side: attributes are taken only from the granted host.
  always_comb begin
    bus.host_gnt_o  = gnt;
    bus.mem_req_o   = |gnt;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = {BeWidth{1'b0}};
    bus.mem_addr_o  = {AddrWidth{1'b0}};
    bus.mem_wdata_o = {DataWidth{1'b0}};
    if (|gnt) begin
      bus.mem_we_o    = bus.host_we_i[gnt_idx];
      bus.mem_be_o    = bus.host_be_i[gnt_idx];
      bus.mem_addr_o  = bus.host_addr_i[gnt_idx];
      bus.mem_wdata_o = bus.host_wdata_i[gnt_idx];
    end
  end

  // Response side and bookkeeping. A response in the reset cycle or the
  // cycle right after it belongs to a transaction that reset abandoned,
  // so it is dropped silently instead of being flagged as spurious.
  always_comb begin
    bus.host_rvalid_o = '0;
    bus.host_rdata_o  = '0;
    owner_vld_d       = |gnt;
    owner_idx_d       = gnt_idx;
    rst_dly_d         = rst_i;
    spurious_d        = spurious_q;
    cnt_d             = cnt_q;
    if (!rst_i && bus.mem_rvalid_i) begin
      if (owner_vld_q) begin
        bus.host_rvalid_o[owner_idx_q] = 1'b1;
        bus.host_rdata_o[owner_idx_q]  = bus.mem_rdata_i;
      end else if (!rst_dly_q) begin
        spurious_d = 1'b1;
      end
    end
    if (&bus.host_req_i && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    rst_dly_q <= rst_dly_d;
    if (rst_i) begin
      owner_vld_q <= 1'b0;
      owner_idx_q <= HostInstr;
      cnt_q       <= '0;
      spurious_q  <= 1'b0;
    end else begin
      owner_vld_q <= owner_vld_d;
      owner_idx_q <= owner_idx_d;
      cnt_q       <= cnt_d;
      spurious_q  <= spurious_d;
    end
  end

  assign conflict_cnt_o = cnt_q;
  assign spurious_o     = spurious_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();
  ram_port_arbiter_if #(.AddrWidth(AW), .DataWidth(DW)) bus4 ();

  logic [15:0] cnt;
  logic        spur;
  logic [3:0]  cnt4;
  logic        spur4;

  ram_port_arbiter #(.AddrWidth(AW), .DataWidth(DW), .CntWidth(16)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .conflict_cnt_o(cnt), .spurious_o(spur));

  ram_port_arbiter #(.AddrWidth(AW), .DataWidth(DW), .CntWidth(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .bus(bus4), .conflict_cnt_o(cnt4), .spurious_o(spur4));

  // RAM: one-cycle latency, byte-enabled writes, writes answer with zero data.
  bit   [31:0] ram [16];
  logic        ram_rvalid = 1'b0;
  logic [31:0] ram_rdata  = '0;
  logic        inj;

  function automatic bit [31:0] merge(bit [31:0] o, logic [31:0] n, logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  always @(posedge clk) begin
    ram_rvalid <= bus.mem_req_o;
    ram_rdata  <= (bus.mem_req_o && !bus.mem_we_o) ? ram[bus.mem_addr_o[5:2]] : 32'h0;
    if (bus.mem_req_o && bus.mem_we_o)
      ram[bus.mem_addr_o[5:2]] <= merge(ram[bus.mem_addr_o[5:2]], bus.mem_wdata_o, bus.mem_be_o);
  end

  assign bus.mem_rvalid_i   = ram_rvalid | inj;
  assign bus.mem_rdata_i    = ram_rdata;
  assign bus4.mem_rvalid_i  = ram_rvalid | inj;
  assign bus4.mem_rdata_i   = ram_rdata;
  assign bus4.host_req_i    = bus.host_req_i;
  assign bus4.host_addr_i   = bus.host_addr_i;
  assign bus4.host_we_i     = bus.host_we_i;
  assign bus4.host_be_i     = bus.host_be_i;
  assign bus4.host_wdata_i  = bus.host_wdata_i;

  // Stimulus state
  logic [1:0]  req;
  logic [31:0] addr [2];
  logic        we   [2];
  logic [3:0]  be   [2];
  logic [31:0] wd   [2];

  // Reference model state
  int          m_last;   // host that won the most recent contention
  int          m_cnt;
  bit          m_spur;
  int          m_owner;  // host whose response is due this cycle, -1 none
  bit [31:0]   m_odata;
  bit          m_rstp;
  bit [31:0]   mmem [16];
  int          cur_w;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Apply inputs, check this cycle against the model, advance the model.
  task automatic settle();
    int w;
    logic [1:0]       eg;
    logic [1:0]       erv;
    logic [1:0][31:0] erd;
    for (int h = 0; h < 2; h++) begin
      bus.host_req_i[h]   = req[h];
      bus.host_addr_i[h]  = addr[h];
      bus.host_we_i[h]    = we[h];
      bus.host_be_i[h]    = be[h];
      bus.host_wdata_i[h] = wd[h];
    end
    #3;
    w = -1;
    if (!rst) begin
      if (req == 2'b11)  w = 1 - m_last;
      else if (req[0])   w = 0;
      else if (req[1])   w = 1;
    end
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    chk("gnt",     bus.host_gnt_o, eg);
    chk("gnt4",    bus4.host_gnt_o, eg);
    chk("mem_req", bus.mem_req_o, (w >= 0));
    chk("mem_we",    bus.mem_we_o,    (w >= 0) ? we[w]   : 1'b0);
    chk("mem_addr",  bus.mem_addr_o,  (w >= 0) ? addr[w] : 32'h0);
    chk("mem_be",    bus.mem_be_o,    (w >= 0) ? be[w]   : 4'h0);
    chk("mem_wdata", bus.mem_wdata_o, (w >= 0) ? wd[w]   : 32'h0);
    erv = '0;
    erd = '0;
    if (!rst && m_owner >= 0) begin
      erv[m_owner] = 1'b1;
      erd[m_owner] = m_odata;
    end
    chk("rvalid", bus.host_rvalid_o, erv);
    chk("rdata",  bus.host_rdata_o, erd);
    chk("cnt",    cnt,  sat(m_cnt, 65535));
    chk("cnt4",   cnt4, sat(m_cnt, 15));
    chk("spur",   spur, m_spur);
    if (rst) begin
      m_last = 0; m_cnt = 0; m_spur = 0; m_owner = -1;
    end else begin
      if (req == 2'b11) begin m_cnt++; m_last = w; end
      if (inj && m_owner < 0 && !m_rstp) m_spur = 1;
      m_owner = w;
      if (w >= 0) begin
        m_odata = we[w] ? 32'h0 : mmem[addr[w][5:2]];
        if (we[w]) mmem[addr[w][5:2]] = merge(mmem[addr[w][5:2]], wd[w], be[w]);
      end
    end
    m_rstp = rst;
    cur_w  = w;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle();
    adv();
  endtask

  task automatic newreq(int h);
    req[h]  = 1'b1;
    addr[h] = 32'h100 + 32'(4 * $urandom_range(0, 15));
    we[h]   = 1'($urandom_range(0, 1));
    be[h]   = 4'($urandom_range(1, 15));
    wd[h]   = $urandom;
  endtask

  initial begin
    logic [5:0] gseq;
    rst = 1'b1; inj = 1'b0; req = 2'b00;
    for (int h = 0; h < 2; h++) begin
      addr[h] = 32'h100; we[h] = 1'b0; be[h] = 4'hF; wd[h] = 32'h0;
    end
    m_last = 0; m_cnt = 0; m_spur = 0; m_owner = -1; m_rstp = 1; cur_w = -1;
    @(posedge clk); #1;

    // Reset with both hosts requesting: no grant, no RAM request.
    req = 2'b11;
    tick(); tick();
    rst = 1'b0; req = 2'b00;
    settle();
    chk("idle_after_rst", {bus.host_gnt_o, bus.host_rvalid_o, bus.mem_req_o, cnt, spur}, '0);
    adv();

    // Lone instruction read of 0x100.
    req = 2'b01; addr[0] = 32'h100; we[0] = 1'b0;
    settle(); chk("lone_gnt0", bus.host_gnt_o, 2'b01); adv();
    req = 2'b00;
    settle(); chk("lone_rvalid", bus.host_rvalid_o, 2'b01); adv();

    // Data write then instruction read of the same word.
    req = 2'b10; addr[1] = 32'h104; we[1] = 1'b1; be[1] = 4'hF; wd[1] = 32'hDEADBEEF;
    settle(); chk("wr_we", bus.mem_we_o, 1'b1); adv();
    req = 2'b01; addr[0] = 32'h104; we[0] = 1'b0;
    settle();
    chk("rd_we", bus.mem_we_o, 1'b0);
    chk("wr_rvalid1", bus.host_rvalid_o, 2'b10);
    adv();
    req = 2'b00;
    settle();
    chk("rd_rvalid0", bus.host_rvalid_o, 2'b01);
    chk("rd_dead", bus.host_rdata_o[0], 32'hDEADBEEF);
    adv();

    // Continuous contention after reset alternates starting with host 1.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      settle(); gseq[5-i] = bus.host_gnt_o[1]; adv();
    end
    req = 2'b00;
    settle();
    chk("rr_seq", gseq, 6'b101010);
    chk("cnt6", cnt, 16'd6);
    adv();

    // Reset pulsed the cycle after a grant, late response then dropped.
    req = 2'b01; addr[0] = 32'h108; we[0] = 1'b0;
    tick();
    rst = 1'b1; req = 2'b00;
    settle(); chk("rst_rvalid", bus.host_rvalid_o, 2'b00); adv();
    rst = 1'b0; inj = 1'b1;
    settle(); chk("post_rst_rvalid", bus.host_rvalid_o, 2'b00); adv();
    inj = 1'b0;
    settle(); chk("post_rst_spur", spur, 1'b0); chk("post_rst_cnt", cnt, 16'd0); adv();

    // Response with no owner: dropped and flagged, flag sticks.
    inj = 1'b1;
    settle(); chk("spur_rvalid", bus.host_rvalid_o, 2'b00); adv();
    inj = 1'b0;
    settle(); chk("spur_set", spur, 1'b1); adv();
    tick(); tick(); tick();
    settle(); chk("spur_sticky", spur, 1'b1); adv();

    // Counter saturation on the narrow instance.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 2'b11;
    repeat (20) tick();
    req = 2'b00;
    settle(); chk("cnt4_sat", cnt4, 4'd15); chk("cnt20", cnt, 16'd20); adv();

    // Randomized traffic with occasional reset and stray responses.
    for (int c = 0; c < 500; c++) begin
      for (int h = 0; h < 2; h++) begin
        if (req[h] && cur_w == h) req[h] = 1'b0;
        if (!req[h] && $urandom_range(0, 9) < 6) newreq(h);
      end
      rst = ($urandom_range(0, 59) == 0);
      inj = (m_owner < 0) && ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
